param_cpu: RTL and testbench
============================

// Module: param_cpu
// PURPOSE
//  Parametrised successor to the single-cycle 8-bit core: same 32-bit ISA plus bne, generic data/register widths.
//  Adds a data-memory port with a BUSYWAIT stall handshake via a 2-state FSM.
//  Sits between instruction memory (drives INSTRUCTION from PC) and the data cache/memory.
// PARAMETERS
//  DATA_W      8   register/ALU/data-memory word width (>=8)
//  REG_ADDR_W  3   register index width; 2**REG_ADDR_W registers
//  ADDR_W      8   data-memory address width (<=DATA_W)
// PORTS
//  CLK            in   1       clock, all state on posedge
//  RESET          in   1       asynchronous, active-high
//  INSTRUCTION    in   32      instruction at PC; ignored while STALL=1
//  PC             out  32      current instruction address
//  STALL          out  1       high in S_MEM; instruction side holds INSTRUCTION
//  MEM_READ       out  1       registered load request
//  MEM_WRITE      out  1       registered store request
//  MEM_ADDRESS    out  ADDR_W  request address
//  MEM_WRITEDATA  out  DATA_W  store data
//  MEM_READDATA   in   DATA_W  load data; valid when MEM_BUSYWAIT=0 in S_MEM
//  MEM_BUSYWAIT   in   1       memory busy; core waits while high
// BEHAVIOUR
//  Format: [31:24] opcode, [23:16] rd/offset, [15:8] rs1, [7:0] rs2/imm; reg fields use low REG_ADDR_W bits.
//  Opcodes: 0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or, 6 j, 7 beq, 8 lwd, 9 lwi, 10 swd, 11 swi, 12 bne.
//  Immediates sign-extended 8->DATA_W; add/sub modulo 2**DATA_W; sub = rs1 + ~rs2 + 1.
//  Undefined opcode: NOP (PC+4, no writeback, no memory request).
//  Branch/jump target = PC+4 + (sext32(offset)<<2), 32-bit wrap. beq taken iff rs1==rs2, bne iff not; j always.
//  Reset (async, immediate): PC=0, state=S_EXEC, all regs=0, STALL/MEM_READ/MEM_WRITE=0, MEM_ADDRESS/MEM_WRITEDATA=0.
//  S_EXEC: non-memory instruction retires at next posedge (PC update, rd write). Latency 1 cycle.
//   Memory instruction: at posedge latch address, data, rd; set MEM_READ|MEM_WRITE; go S_MEM; PC held.
//   Load: rd=[23:16], address=reg[[7:0]] (lwd) or imm[7:0] zero-extended (lwi).
//   Store: data=reg[[15:8]], address=reg[[7:0]] (swd) or imm (swi). Address = low ADDR_W bits.
//  S_MEM: request held stable, STALL=1.
//   Posedge with MEM_BUSYWAIT=0: load writes MEM_READDATA to latched rd; PC+=4; request cleared; go S_EXEC.
//   Memory instruction latency = 2 + busy cycles; BUSYWAIT low in first S_MEM cycle = zero-wait completion.
//  Register file: 2 async reads, 1 sync write. No hardwired zero register.
//   Same-edge write and read of one register: read returns old value until the edge.
//  Reset in S_MEM aborts the access; request drops asynchronously; no writeback.
// CONFIGURATION
//  PCPU_SHIFT_EN defined: opcodes 13 sll, 14 srl, 15 sra, 16 ror. rd = rs1 shifted by imm[7:0] mod DATA_W.
//   Single-cycle in S_EXEC.
//  Undefined: opcodes 13-16 are NOP.
// STRUCTURE
//  pcpu_pkg: opcode localparams, field-slice constants, FSM state encoding (S_EXEC=0, S_MEM=1).
//  Sub-module: param_reg_file (DATA_W, REG_ADDR_W; async RESET clears all registers).
//  Decode, ALU, branch compare, PC logic and FSM live in param_cpu.
// TESTING
//  1. RESET mid-run -> PC=0, MEM_READ=0, STALL=0 in the same cycle; r0..r7=0.
//  2. loadi r1,5; loadi r2,3; sub r3,r1,r2 -> r3=2; sub r4,r2,r1 -> r4=8'hFE (DATA_W=8).
//  3. beq r1,r1,off=-2 at PC=16 -> PC=12; bne r1,r1 at PC=12 -> PC=16; j off=1 at PC=0 -> PC=8.
//  4. lwi r5,0x20; BUSYWAIT high 3 cycles, READDATA=0xA5 -> r5=0xA5, PC advances after 5 cycles.
//   STALL high for 4 cycles.
//  5. swd r1->[r2]; zero-wait memory -> MEM_WRITE=1, ADDRESS=3, WRITEDATA=5 for 1 cycle; PC+4 after 2 cycles.
//  6. DATA_W=16, REG_ADDR_W=4, PCPU_SHIFT_EN: loadi r9,-1; srl r10,r9,4 -> r10=16'h0FFF.
//   Same run without the macro: opcode 14 is NOP, r10 unchanged.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared definitions for param_cpu: opcodes, instruction field positions, FSM states.
// Also holds the branch-target helper used by the core.
package pcpu_pkg;

  localparam int OPC_LSB = 24;
  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 0;
  localparam int FIELD_W = 8;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_BNE   = 8'd12;
  localparam logic [7:0] OP_SLL   = 8'd13;
  localparam logic [7:0] OP_SRL   = 8'd14;
  localparam logic [7:0] OP_SRA   = 8'd15;
  localparam logic [7:0] OP_ROR   = 8'd16;

  typedef enum logic {
    S_EXEC = 1'b0,
    S_MEM  = 1'b1
  } state_t;

  // Offset counts words relative to the following instruction.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [7:0] off);
    return pc + 32'd4 + {{22{off[7]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/param_reg_file.sv
// Register file: two asynchronous read ports, one write port on posedge clk.
// Asynchronous active-high rst clears every register; no hardwired zero register.
module param_reg_file
  import pcpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);

  logic [DATA_W-1:0] regs [2**REG_ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/param_cpu.sv
// Single-cycle core with a stalling data-memory port: ALU/branch ops retire in 1 cycle, memory ops in 2 + busy cycles.
// MEM_BUSYWAIT holds the core in S_MEM with the request stable; PCPU_SHIFT_EN adds sll/srl/sra/ror.
module param_cpu
  import pcpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int ADDR_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  output logic [31:0]       PC,
  output logic              STALL,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  state_t                state, state_nxt;
  logic [31:0]           pc_nxt, pc_plus4;
  logic                  mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0]     addr_nxt;
  logic [DATA_W-1:0]     wdata_nxt;
  logic [REG_ADDR_W-1:0] mem_rd, mem_rd_nxt;

  logic [7:0]            opcode, off, imm, shamt;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0]     rs1_val, rs2_val, imm_sext, imm_zext;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  unused_bits;

  assign opcode   = INSTRUCTION[OPC_LSB +: FIELD_W];
  assign off      = INSTRUCTION[RD_LSB +: FIELD_W];
  assign imm      = INSTRUCTION[RS2_LSB +: FIELD_W];
  assign rd       = INSTRUCTION[RD_LSB +: REG_ADDR_W];
  assign rs1      = INSTRUCTION[RS1_LSB +: REG_ADDR_W];
  assign rs2      = INSTRUCTION[RS2_LSB +: REG_ADDR_W];
  assign imm_sext = DATA_W'($signed(imm));
  assign imm_zext = DATA_W'(imm);
  assign shamt    = 8'(32'(imm) % DATA_W);
  assign pc_plus4 = PC + 32'd4;
  assign STALL    = (state == S_MEM);
  assign unused_bits = ^INSTRUCTION[RS1_LSB +: FIELD_W];

  param_reg_file #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rf (
    .clk    (CLK),
    .rst    (RESET),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    state_nxt     = state;
    pc_nxt        = PC;
    mem_read_nxt  = MEM_READ;
    mem_write_nxt = MEM_WRITE;
    addr_nxt      = MEM_ADDRESS;
    wdata_nxt     = MEM_WRITEDATA;
    mem_rd_nxt    = mem_rd;
    rf_we         = 1'b0;
    rf_waddr      = rd;
    rf_wdata      = '0;
    unique case (state)
      S_EXEC: begin
        pc_nxt = pc_plus4;
        case (opcode)
          OP_LOADI: begin rf_we = 1'b1; rf_wdata = imm_sext; end
          OP_MOV:   begin rf_we = 1'b1; rf_wdata = rs2_val; end
          OP_ADD:   begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
          OP_SUB:   begin rf_we = 1'b1; rf_wdata = rs1_val + ~rs2_val + DATA_W'(1); end
          OP_AND:   begin rf_we = 1'b1; rf_wdata = rs1_val & rs2_val; end
          OP_OR:    begin rf_we = 1'b1; rf_wdata = rs1_val | rs2_val; end
          OP_J:     pc_nxt = branch_target(PC, off);
          OP_BEQ:   if (rs1_val == rs2_val) pc_nxt = branch_target(PC, off);
          OP_BNE:   if (rs1_val != rs2_val) pc_nxt = branch_target(PC, off);
          OP_LWD, OP_LWI: begin
            pc_nxt       = PC;
            state_nxt    = S_MEM;
            mem_read_nxt = 1'b1;
            mem_rd_nxt   = rd;
            addr_nxt     = (opcode == OP_LWD) ? rs2_val[ADDR_W-1:0] : imm_zext[ADDR_W-1:0];
          end
          OP_SWD, OP_SWI: begin
            pc_nxt        = PC;
            state_nxt     = S_MEM;
            mem_write_nxt = 1'b1;
            wdata_nxt     = rs1_val;
            addr_nxt      = (opcode == OP_SWD) ? rs2_val[ADDR_W-1:0] : imm_zext[ADDR_W-1:0];
          end
`ifdef PCPU_SHIFT_EN
          OP_SLL: begin rf_we = 1'b1; rf_wdata = rs1_val << shamt; end
          OP_SRL: begin rf_we = 1'b1; rf_wdata = rs1_val >> shamt; end
          OP_SRA: begin rf_we = 1'b1; rf_wdata = DATA_W'($signed(rs1_val) >>> shamt); end
          // A zero rotate works out because a shift by DATA_W yields zero.
          OP_ROR: begin
            rf_we    = 1'b1;
            rf_wdata = (rs1_val >> shamt) | (rs1_val << (DATA_W - int'(shamt)));
          end
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        if (!MEM_BUSYWAIT) begin
          rf_we         = MEM_READ;
          rf_waddr      = mem_rd;
          rf_wdata      = MEM_READDATA;
          pc_nxt        = pc_plus4;
          state_nxt     = S_EXEC;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          addr_nxt      = '0;
          wdata_nxt     = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= S_EXEC;
      PC            <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      mem_rd        <= '0;
    end else begin
      state         <= state_nxt;
      PC            <= pc_nxt;
      MEM_READ      <= mem_read_nxt;
      MEM_WRITE     <= mem_write_nxt;
      MEM_ADDRESS   <= addr_nxt;
      MEM_WRITEDATA <= wdata_nxt;
      mem_rd        <= mem_rd_nxt;
    end
  end

endmodule

// File: tb/tb_param_cpu.sv
// Directed bench for param_cpu: an 8-bit core for ALU/branch/memory/reset cases and a
// 16-bit, 16-register core for the optional shift opcodes (PCPU_SHIFT_EN).
module tb_param_cpu;

  logic        clk;
  logic        rst;
  logic [31:0] instr, instr16;
  logic [31:0] pc, pc16;
  logic        stall, stall16, mrd, mrd16, mwr, mwr16;
  logic [7:0]  maddr, maddr16;
  logic [7:0]  mwdata, mrdata;
  logic [15:0] mwdata16, mrdata16;
  logic        busy, busy16;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  param_cpu dut (
    .CLK(clk), .RESET(rst), .INSTRUCTION(instr), .PC(pc), .STALL(stall),
    .MEM_READ(mrd), .MEM_WRITE(mwr), .MEM_ADDRESS(maddr), .MEM_WRITEDATA(mwdata),
    .MEM_READDATA(mrdata), .MEM_BUSYWAIT(busy)
  );

  param_cpu #(.DATA_W(16), .REG_ADDR_W(4), .ADDR_W(8)) dut16 (
    .CLK(clk), .RESET(rst), .INSTRUCTION(instr16), .PC(pc16), .STALL(stall16),
    .MEM_READ(mrd16), .MEM_WRITE(mwr16), .MEM_ADDRESS(maddr16), .MEM_WRITEDATA(mwdata16),
    .MEM_READDATA(mrdata16), .MEM_BUSYWAIT(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int a, input int b, input int c);
    return {8'(op), 8'(a), 8'(b), 8'(c)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [31:0] i);
    instr = i;
    tick();
  endtask

  localparam logic [31:0] NOP = 32'hFF00_0000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr = NOP; instr16 = NOP;
    busy = 1'b0; busy16 = 1'b0; mrdata = '0; mrdata16 = '0;
    tick(); tick();
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_mrd", {31'd0, mrd}, 32'd0);
    check_eq("rst_mwr", {31'd0, mwr}, 32'd0);
    check_eq("rst_addr", {24'd0, maddr}, 32'd0);
    rst = 1'b0;

    exec(ins(0, 1, 0, 5));
    exec(ins(0, 2, 0, 3));
    exec(ins(3, 3, 1, 2));
    exec(ins(3, 4, 2, 1));
    check_eq("sub_r3", {24'd0, dut.u_rf.regs[3]}, 32'h02);
    check_eq("sub_r4", {24'd0, dut.u_rf.regs[4]}, 32'hFE);
    check_eq("pc_16", pc, 32'd16);

    exec(ins(7, 8'hFE, 1, 1));
    check_eq("beq_back", pc, 32'd12);
    exec(ins(12, 5, 1, 1));
    check_eq("bne_not", pc, 32'd16);
    exec(ins(12, 1, 1, 2));
    check_eq("bne_taken", pc, 32'd24);
    exec(ins(7, 3, 1, 2));
    check_eq("beq_not", pc, 32'd28);

    exec(ins(4, 5, 1, 2));
    exec(ins(5, 6, 1, 2));
    exec(ins(1, 7, 0, 1));
    exec(ins(2, 0, 1, 2));
    check_eq("and_r5", {24'd0, dut.u_rf.regs[5]}, 32'h01);
    check_eq("or_r6", {24'd0, dut.u_rf.regs[6]}, 32'h07);
    check_eq("mov_r7", {24'd0, dut.u_rf.regs[7]}, 32'h05);
    check_eq("add_r0", {24'd0, dut.u_rf.regs[0]}, 32'h08);

    exec(ins(8'hFF, 1, 0, 0));
    check_eq("nop_pc", pc, 32'd48);
    check_eq("nop_r1", {24'd0, dut.u_rf.regs[1]}, 32'h05);
    check_eq("nop_mrd", {31'd0, mrd}, 32'd0);

    // lwi with three busy cycles; the instruction bus carries junk while stalled
    busy = 1'b1; mrdata = 8'hA5; stall_cnt = 0;
    exec(ins(9, 5, 0, 8'h20));
    instr = ins(0, 1, 0, 99);
    check_eq("lwi_mrd", {31'd0, mrd}, 32'd1);
    check_eq("lwi_addr", {24'd0, maddr}, 32'h20);
    check_eq("lwi_pc_hold", pc, 32'd48);
    if (stall) stall_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("lwi_busy_pc", pc, 32'd48);
      if (stall) stall_cnt++;
    end
    busy = 1'b0;
    tick();
    if (stall) stall_cnt++;
    check_eq("lwi_stall_cnt", stall_cnt, 32'd4);
    check_eq("lwi_pc_next", pc, 32'd52);
    check_eq("lwi_r5", {24'd0, dut.u_rf.regs[5]}, 32'hA5);
    check_eq("lwi_mrd_clr", {31'd0, mrd}, 32'd0);
    check_eq("stall_ignored_r1", {24'd0, dut.u_rf.regs[1]}, 32'h05);

    exec(ins(10, 0, 1, 2));
    instr = NOP;
    check_eq("swd_mwr", {31'd0, mwr}, 32'd1);
    check_eq("swd_addr", {24'd0, maddr}, 32'd3);
    check_eq("swd_data", {24'd0, mwdata}, 32'd5);
    check_eq("swd_stall", {31'd0, stall}, 32'd1);
    check_eq("swd_pc_hold", pc, 32'd52);
    tick();
    check_eq("swd_mwr_clr", {31'd0, mwr}, 32'd0);
    check_eq("swd_pc_next", pc, 32'd56);

    mrdata = 8'h3C;
    exec(ins(8, 6, 0, 2));
    instr = NOP;
    check_eq("lwd_addr", {24'd0, maddr}, 32'd3);
    tick();
    check_eq("lwd_r6", {24'd0, dut.u_rf.regs[6]}, 32'h3C);
    check_eq("lwd_pc", pc, 32'd60);

    exec(ins(11, 0, 2, 8'h40));
    instr = NOP;
    check_eq("swi_addr", {24'd0, maddr}, 32'h40);
    check_eq("swi_data", {24'd0, mwdata}, 32'd3);
    tick();
    check_eq("swi_pc", pc, 32'd64);

    // reset while a load is stalled in S_MEM
    busy = 1'b1;
    exec(ins(9, 7, 0, 8'h11));
    instr = NOP;
    check_eq("pre_rst_mrd", {31'd0, mrd}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_pc", pc, 32'd0);
    check_eq("mid_rst_mrd", {31'd0, mrd}, 32'd0);
    check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
    for (int r = 0; r < 8; r++) check_eq($sformatf("mid_rst_r%0d", r), {24'd0, dut.u_rf.regs[r]}, 32'd0);
    #1 rst = 1'b0; busy = 1'b0;

    exec(ins(6, 1, 0, 0));
    check_eq("j_fwd", pc, 32'd8);

    instr = NOP;
    instr16 = ins(0, 9, 0, 8'hFF);   tick();
    instr16 = ins(14, 10, 9, 4);     tick();
    instr16 = ins(15, 11, 9, 4);     tick();
    instr16 = ins(13, 12, 9, 20);    tick();
    instr16 = ins(0, 13, 0, 8'h12);  tick();
    instr16 = ins(16, 14, 13, 4);    tick();
    instr16 = NOP;
    check_eq("w16_r9", {16'd0, dut16.u_rf.regs[9]}, 32'hFFFF);
    check_eq("w16_r13", {16'd0, dut16.u_rf.regs[13]}, 32'h0012);
    check_eq("w16_pc", pc16, 32'd28);
`ifdef PCPU_SHIFT_EN
    check_eq("srl_r10", {16'd0, dut16.u_rf.regs[10]}, 32'h0FFF);
    check_eq("sra_r11", {16'd0, dut16.u_rf.regs[11]}, 32'hFFFF);
    check_eq("sll_mod_r12", {16'd0, dut16.u_rf.regs[12]}, 32'hFFF0);
    check_eq("ror_r14", {16'd0, dut16.u_rf.regs[14]}, 32'h2001);
`else
    check_eq("srl_nop_r10", {16'd0, dut16.u_rf.regs[10]}, 32'h0000);
    check_eq("sra_nop_r11", {16'd0, dut16.u_rf.regs[11]}, 32'h0000);
    check_eq("sll_nop_r12", {16'd0, dut16.u_rf.regs[12]}, 32'h0000);
    check_eq("ror_nop_r14", {16'd0, dut16.u_rf.regs[14]}, 32'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
